line_peak_finder: RTL and testbench

Downstream consumer of the image line block RAM in the laser-line scanner. After the capture side finishes writing one image line, this block scans the RAM and finds the brightest column, which is the laser stripe position. It reports that column, its intensity and a threshold verdict with a one-cycle done pulse to the depth-computation stage. The block only reads the RAM; it drives the RAM's address port while busy.

---
 rtl/line_peak_finder_if.sv | 33 +++
 rtl/line_peak_finder.sv | 158 +++++++++++++++
 tb/tb_line_peak_finder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/line_peak_finder_if.sv
// ============================================================================
// line_peak_finder_if : scan request, line-RAM read port and result bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface line_peak_finder_if #(
   parameter int LOGSIZE = 10,
   parameter int WIDTH   = 8
);
   logic               start;
   logic [WIDTH-1:0]   threshold;
   logic [LOGSIZE-1:0] bram_addr;
   logic [WIDTH-1:0]   bram_dout;
   logic               busy;
   logic               done;
   logic [LOGSIZE-1:0] peak_col;
   logic [WIDTH-1:0]   peak_val;
   logic               found;

   // master = requester plus line RAM; slave = the peak finder
   modport master (
      output start, threshold, bram_dout,
      input  bram_addr, busy, done, peak_col, peak_val, found
   );

   modport slave (
      input  start, threshold, bram_dout,
      output bram_addr, busy, done, peak_col, peak_val, found
   );
endinterface

`default_nettype wire

// File: rtl/line_peak_finder.sv
// ============================================================================
// line_peak_finder : scans one image line in block RAM for its brightest column
// Optional macro LINE_PEAK_PLATEAU_EN reports the centre of a flat-topped peak.
// Rev 1.0
// ============================================================================
`default_nettype none

module line_peak_finder #(
   parameter int LOGSIZE  = 10,
   parameter int WIDTH    = 8,
   parameter int LINE_LEN = 640
) (
   input  wire logic         clk,
   input  wire logic         reset,
   line_peak_finder_if.slave bus
);

   localparam logic [LOGSIZE-1:0] C_LAST_COL = LOGSIZE'(LINE_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_DRAIN  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LOGSIZE-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]   thr_q, thr_d;
   logic               tag_vld_q, tag_vld_d;
   logic [LOGSIZE-1:0] tag_col_q, tag_col_d;
   logic [WIDTH-1:0]   max_q, max_d;
   logic [LOGSIZE-1:0] first_q, first_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [LOGSIZE-1:0] pcol_q, pcol_d;
   logic [WIDTH-1:0]   pval_q, pval_d;
   logic               found_q, found_d;
`ifdef LINE_PEAK_PLATEAU_EN
   logic [LOGSIZE-1:0] last_q, last_d;
   logic [LOGSIZE:0]   centre_sum;
   assign centre_sum = {1'b0, first_q} + {1'b0, last_q};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      thr_d     = thr_q;
      max_d     = max_q;
      first_d   = first_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pcol_d    = pcol_q;
      pval_d    = pval_q;
      found_d   = found_q;
      tag_vld_d = (state_q == S_SCAN);
      tag_col_d = addr_q;
`ifdef LINE_PEAK_PLATEAU_EN
      last_d    = last_q;
`endif

      // Column 0 seeds the running max; later columns need a strict win
      if (tag_vld_q) begin
         if ((tag_col_q == '0) || (bus.bram_dout > max_q)) begin
            max_d   = bus.bram_dout;
            first_d = tag_col_q;
`ifdef LINE_PEAK_PLATEAU_EN
            last_d  = tag_col_q;
         end else if (bus.bram_dout == max_q) begin
            last_d  = tag_col_q;
`endif
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               thr_d   = bus.threshold;
               max_d   = '0;
               first_d = '0;
`ifdef LINE_PEAK_PLATEAU_EN
               last_d  = '0;
`endif
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (addr_q == C_LAST_COL) state_d = S_DRAIN;
            else                      addr_d  = addr_q + 1'b1;
         end
         S_DRAIN: state_d = S_REPORT;
         S_REPORT: begin
            pval_d  = max_q;
`ifdef LINE_PEAK_PLATEAU_EN
            pcol_d  = centre_sum[LOGSIZE:1];
`else
            pcol_d  = first_q;
`endif
            found_d = (max_q >= thr_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         thr_q     <= '0;
         tag_vld_q <= 1'b0;
         tag_col_q <= '0;
         max_q     <= '0;
         first_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pcol_q    <= '0;
         pval_q    <= '0;
         found_q   <= 1'b0;
`ifdef LINE_PEAK_PLATEAU_EN
         last_q    <= '0;
`endif
      end else begin
         addr_q    <= addr_d;
         thr_q     <= thr_d;
         tag_vld_q <= tag_vld_d;
         tag_col_q <= tag_col_d;
         max_q     <= max_d;
         first_q   <= first_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pcol_q    <= pcol_d;
         pval_q    <= pval_d;
         found_q   <= found_d;
`ifdef LINE_PEAK_PLATEAU_EN
         last_q    <= last_d;
`endif
      end
   end

   assign bus.bram_addr = addr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.peak_col  = pcol_q;
   assign bus.peak_val  = pval_q;
   assign bus.found     = found_q;

endmodule

`default_nettype wire

// File: tb/tb_line_peak_finder.sv
// ============================================================================
// tb_line_peak_finder : directed and random line scans against a line model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_peak_finder;

   localparam int LOGSIZE  = 4;
   localparam int WIDTH    = 8;
   localparam int LINE_LEN = 8;

   logic clk;
   logic reset;

   line_peak_finder_if #(.LOGSIZE(LOGSIZE), .WIDTH(WIDTH)) bus ();

   line_peak_finder #(.LOGSIZE(LOGSIZE), .WIDTH(WIDTH), .LINE_LEN(LINE_LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [WIDTH-1:0] mem [1 << LOGSIZE];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous line RAM: data for the address sampled at an edge appears after it
   always @(posedge clk) bus.bram_dout <= mem[bus.bram_addr];

   int n_total = 0;
   int n_pass  = 0;
   int prev_col = 0, prev_val = 0, prev_found = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: global max, its lowest and highest columns, threshold verdict
   task automatic model(input int thr, output int col, output int val, output int fnd);
      int first, last;
      val = 0;
      for (int i = 0; i < LINE_LEN; i++) if (int'(mem[i]) > val) val = int'(mem[i]);
      first = -1;
      last  = 0;
      for (int i = 0; i < LINE_LEN; i++) begin
         if (int'(mem[i]) == val) begin
            if (first < 0) first = i;
            last = i;
         end
      end
`ifdef LINE_PEAK_PLATEAU_EN
      col = (first + last) / 2;
`else
      col = first;
`endif
      fnd = (val >= thr) ? 1 : 0;
   endtask

   task automatic do_scan(input int thr, input int inj);
      int exp_col, exp_val, exp_fnd;
      int lat, done_cnt, busy_at_done, addr_ok, held_ok;
      model(thr, exp_col, exp_val, exp_fnd);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.threshold = WIDTH'(thr);
      @(posedge clk); #1;
      bus.start     = 1'b0;
      check("busy_after_start", int'(bus.busy), 1);
      lat = -1; done_cnt = 0; busy_at_done = -1; addr_ok = 1; held_ok = 1;
      for (int c = 1; c <= 20; c++) begin
         if (c <= LINE_LEN && int'(bus.bram_addr) != c - 1) addr_ok = 0;
         if (c == inj) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (c < LINE_LEN &&
             (int'(bus.peak_col) != prev_col || int'(bus.peak_val) != prev_val ||
              int'(bus.found) != prev_found)) held_ok = 0;
         if (bus.done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = c;
               busy_at_done = int'(bus.busy);
            end
         end
      end
      check("latency", lat, LINE_LEN + 2);
      check("done_count", done_cnt, 1);
      check("busy_at_done", busy_at_done, 0);
      check("addr_sequence", addr_ok, 1);
      check("result_held", held_ok, 1);
      check("peak_col", int'(bus.peak_col), exp_col);
      check("peak_val", int'(bus.peak_val), exp_val);
      check("found", int'(bus.found), exp_fnd);
      prev_col = exp_col; prev_val = exp_val; prev_found = exp_fnd;
   endtask

   task automatic load(input logic [WIDTH-1:0] pat [LINE_LEN]);
      for (int i = 0; i < LINE_LEN; i++) mem[i] = pat[i];
   endtask

   task automatic reset_mid_scan();
      int seen, dcnt;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.threshold = 8'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         if (int'(bus.bram_addr) == 4) seen = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("reached_addr4", seen, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_addr", int'(bus.bram_addr), 0);
      check("rst_async_busy", int'(bus.busy), 0);
      check("rst_async_done", int'(bus.done), 0);
      check("rst_async_col", int'(bus.peak_col), 0);
      check("rst_async_val", int'(bus.peak_val), 0);
      check("rst_async_found", int'(bus.found), 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (bus.done) dcnt++;
      end
      check("no_done_after_abort", dcnt, 0);
      prev_col = 0; prev_val = 0; prev_found = 0;
   endtask

   logic [WIDTH-1:0] pat [LINE_LEN];

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.threshold = '0;
      for (int i = 0; i < (1 << LOGSIZE); i++) mem[i] = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_addr", int'(bus.bram_addr), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_col", int'(bus.peak_col), 0);
      check("reset_val", int'(bus.peak_val), 0);
      check("reset_found", int'(bus.found), 0);
      @(negedge clk);
      reset = 1'b0;

      pat = '{8'd3, 8'd9, 8'd4, 8'd200, 8'd7, 8'd1, 8'd0, 8'd5};
      load(pat);
      do_scan(100, 0);
      do_scan(201, 0);
      pat = '{8'd10, 8'd50, 8'd50, 8'd50, 8'd2, 8'd50, 8'd0, 8'd0};
      load(pat);
      do_scan(40, 0);
      pat = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      load(pat);
      do_scan(0, 0);
      pat = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd250};
      load(pat);
      do_scan(250, 0);

      reset_mid_scan();
      pat = '{8'd3, 8'd9, 8'd4, 8'd200, 8'd7, 8'd1, 8'd0, 8'd5};
      load(pat);
      do_scan(100, 0);
      do_scan(150, 3);

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < LINE_LEN; i++) begin
            if (r % 2 == 0) mem[i] = WIDTH'($urandom_range(0, 255));
            else            mem[i] = WIDTH'($urandom_range(0, 3) * 60);
         end
         do_scan(int'($urandom_range(0, 255)), (r % 5 == 0) ? 2 + r % 4 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
